// File: rtl/mlp_eval_seq_if.sv
// mlp_eval_seq_if: bundles the signals between the evaluation sequencer and its host/net.
//   master modport: host/testbench side. It drives start, the weight write port and the net output y_in.
//   slave modport : sequencer side. It drives w_ready, the weights w0..w8, x_out, busy, done, pass and err_mask.
interface mlp_eval_seq_if;
   logic              start;
   logic              w_valid;
   logic [3:0]        w_idx;
   logic signed [3:0] w_data;
   logic              w_ready;
   logic signed [3:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
   logic [1:0]        x_out;
   logic              y_in;
   logic              busy;
   logic              done;
   logic              pass;
   logic [3:0]        err_mask;

   modport master (
      output start, w_valid, w_idx, w_data, y_in,
      input  w_ready, w0, w1, w2, w3, w4, w5, w6, w7, w8,
      input  x_out, busy, done, pass, err_mask
   );

   modport slave (
      input  start, w_valid, w_idx, w_data, y_in,
      output w_ready, w0, w1, w2, w3, w4, w5, w6, w7, w8,
      output x_out, busy, done, pass, err_mask
   );
endinterface

// File: rtl/mlp_eval_seq.sv
// mlp_eval_seq: on-chip evaluation sequencer for the 2-input, 3-neuron simpleNet MLP.
// It holds the nine signed 4-bit weights that drive the net. A run sweeps x through 3,2,1,0.
// Each pattern is held for SETTLE_CYCLES clocks, and then y_in is sampled and compared with TRUTH[x].
//   clk, rst_n : clock; asynchronous active-low reset
//   bus.start  : run request, sampled only while idle
//   bus.w_*    : weight write port, accepted while w_ready (= !busy)
//   bus.w0..w8 : weight registers
//   bus.x_out / bus.y_in : net input / net output
//   bus.busy, bus.done (1-cycle pulse), bus.pass, bus.err_mask : run status
// SETTLE_CYCLES must be in 1..15. The settle counter is 4 bits wide.
module mlp_eval_seq #(
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter logic [3:0]  TRUTH         = 4'b0110
) (
   input logic           clk,
   input logic           rst_n,
   mlp_eval_seq_if.slave bus
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [3:0] RELOAD  = 4'(SETTLE_CYCLES - 1);

   logic [0:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        x_q, x_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [3:0]        err_q, err_d;
   logic signed [3:0] w_q [9];
   logic signed [3:0] w_d [9];
   logic              busy;

   assign busy = (state_q == ST_RUN);

   // Weight writes. An index above 8 matches no register and is dropped.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         w_d[i] = w_q[i];
         if (bus.w_valid && !busy && (bus.w_idx == 4'(i)))
            w_d[i] = bus.w_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               x_d     = 2'd3;
               cnt_d   = RELOAD;
               err_d   = 4'b0000;
               pass_d  = 1'b0;
            end
         end
         default: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               err_d[x_q] = bus.y_in ^ TRUTH[x_q];
               if (x_q != 2'd0) begin
                  x_d   = x_q - 2'd1;
                  cnt_d = RELOAD;
               end else begin
                  // The verdict includes the bit sampled on this same edge.
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 4'b0000);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         x_q     <= 2'd0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 4'b0000;
         for (int i = 0; i < 9; i++) w_q[i] <= 4'sd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         for (int i = 0; i < 9; i++) w_q[i] <= w_d[i];
      end
   end

   assign bus.w_ready  = !busy;
   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.err_mask = err_q;
   assign bus.x_out    = x_q;
   assign bus.w0       = w_q[0];
   assign bus.w1       = w_q[1];
   assign bus.w2       = w_q[2];
   assign bus.w3       = w_q[3];
   assign bus.w4       = w_q[4];
   assign bus.w5       = w_q[5];
   assign bus.w6       = w_q[6];
   assign bus.w7       = w_q[7];
   assign bus.w8       = w_q[8];
endmodule

// File: tb/tb_mlp_eval_seq.sv
// tb_mlp_eval_seq: directed bench for mlp_eval_seq.
// Instance A uses the default TRUTH (XOR). Instance B uses TRUTH=4'b1111 and follows the same start.
// Each instance is driven by a net stub with 1-cycle latency.
module tb_mlp_eval_seq;
   localparam int         S       = 3;
   localparam logic [3:0] TRUTH_A = 4'b0110;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   stub_one = 1'b0;   // 0: y = x[1]^x[0], 1: y stuck at 1
   logic y_a = 1'b0, y_b = 1'b0;
   bit   chk_en = 1'b0;
   int   n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   mlp_eval_seq_if ifa();
   mlp_eval_seq_if ifb();

   mlp_eval_seq #(.SETTLE_CYCLES(S)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   mlp_eval_seq #(.SETTLE_CYCLES(S), .TRUTH(4'b1111)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   assign ifa.y_in    = y_a;
   assign ifb.y_in    = y_b;
   assign ifb.start   = ifa.start;
   assign ifb.w_valid = 1'b0;
   assign ifb.w_idx   = 4'd0;
   assign ifb.w_data  = 4'sd0;

   // Net stubs
   always @(posedge clk) begin
      y_a <= stub_one ? 1'b1 : (ifa.x_out[1] ^ ifa.x_out[0]);
      y_b <= stub_one ? 1'b1 : (ifb.x_out[1] ^ ifb.x_out[0]);
   end

   logic signed [3:0] dut_w [9];
   always_comb begin
      dut_w[0] = ifa.w0; dut_w[1] = ifa.w1; dut_w[2] = ifa.w2;
      dut_w[3] = ifa.w3; dut_w[4] = ifa.w4; dut_w[5] = ifa.w5;
      dut_w[6] = ifa.w6; dut_w[7] = ifa.w7; dut_w[8] = ifa.w8;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Expected mask of a complete run, from the steady-state net function.
   function automatic logic [3:0] full_mask(input bit one, input logic [3:0] truth);
      logic [3:0] m;
      bit y;
      for (int k = 0; k < 4; k++) begin
         y = one ? 1'b1 : ((k == 1) || (k == 2));
         m[k] = y ^ truth[k];
      end
      return m;
   endfunction

   // Timeline model of instance A. A run started on edge s ends on edge s+4S.
   // x_out is 3 - elapsed/S while the run is in progress.
   bit                m_busy = 0, m_done = 0, m_pass = 0;
   logic [3:0]        m_mask = 0;
   logic [1:0]        m_x = 0;
   int                m_el = 0;
   logic signed [3:0] m_w [9] = '{default: 4'sd0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_done <= 0; m_pass <= 0; m_mask <= 0; m_x <= 0; m_el <= 0;
         for (int i = 0; i < 9; i++) m_w[i] <= 4'sd0;
      end else begin
         for (int i = 0; i < 9; i++)
            if (ifa.w_valid && !m_busy && (int'(ifa.w_idx) == i)) m_w[i] <= ifa.w_data;
         m_done <= 0;
         if (!m_busy) begin
            if (ifa.start) begin
               m_busy <= 1; m_el <= 0; m_x <= 2'd3; m_mask <= 0; m_pass <= 0;
            end
         end else begin
            m_el <= m_el + 1;
            if (m_el + 1 == 4 * S) begin
               m_busy <= 0; m_done <= 1; m_x <= 2'd0;
               m_mask <= full_mask(stub_one, TRUTH_A);
               m_pass <= (full_mask(stub_one, TRUTH_A) == 4'b0000);
            end else begin
               m_x <= 2'(3 - (m_el + 1) / S);
            end
         end
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("x_out", int'(ifa.x_out), int'(m_x));
         chk("busy", int'(ifa.busy), int'(m_busy));
         chk("done", int'(ifa.done), int'(m_done));
         chk("w_ready", int'(ifa.w_ready), int'(!m_busy));
         for (int i = 0; i < 9; i++) chk($sformatf("w%0d", i), int'(dut_w[i]), int'(m_w[i]));
         if (!m_busy) begin
            chk("err_mask", int'(ifa.err_mask), int'(m_mask));
            chk("pass", int'(ifa.pass), int'(m_pass));
         end
      end
   end

   int wtab [9] = '{2, 2, 1, 2, 2, 3, 2, -2, 1};
   int xseq [12] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0};
   int rec_x [16];
   int rec_b [40];
   int rec_d [16];

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 60; k++) begin
         if (!ifa.busy) break;
         @(negedge clk);
      end
      if (k == 60) chk({nm, " timeout"}, 1, 0);
      @(negedge clk);
   endtask

   initial begin
      int cnt, r0, r1, nd;
      ifa.start = 0; ifa.w_valid = 0; ifa.w_idx = 0; ifa.w_data = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset values
      chk("rst x_out", int'(ifa.x_out), 0);
      chk("rst busy", int'(ifa.busy), 0);
      chk("rst done", int'(ifa.done), 0);
      chk("rst pass", int'(ifa.pass), 0);
      chk("rst err_mask", int'(ifa.err_mask), 0);
      chk("rst w_ready", int'(ifa.w_ready), 1);
      chk("rst w8", int'(ifa.w8), 0);
      rst_n = 1;
      chk_en = 1;

      // Weight load
      for (int i = 0; i < 9; i++) begin
         ifa.w_valid = 1; ifa.w_idx = 4'(i); ifa.w_data = 4'(wtab[i]);
         @(negedge clk);
      end
      ifa.w_valid = 1; ifa.w_idx = 4'd9; ifa.w_data = 4'sd5;
      @(negedge clk);
      ifa.w_valid = 0;
      for (int i = 0; i < 9; i++) chk($sformatf("load w%0d", i), int'(dut_w[i]), wtab[i]);

      // XOR run. A busy write and a start pulse during RUN are both ignored.
      stub_one = 0;
      ifa.start = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rec_x[i] = int'(ifa.x_out); rec_b[i] = int'(ifa.busy); rec_d[i] = int'(ifa.done);
         if (i == 0) ifa.start = 0;
         if (i == 2) begin ifa.w_valid = 1; ifa.w_idx = 4'd0; ifa.w_data = 4'sd7; end
         if (i == 3) ifa.w_valid = 0;
         if (i == 5) ifa.start = 1;
         if (i == 6) ifa.start = 0;
      end
      for (int i = 0; i < 12; i++) chk($sformatf("xor x_out[%0d]", i), rec_x[i], xseq[i]);
      cnt = 0; nd = 0;
      for (int i = 0; i < 16; i++) begin cnt += rec_b[i]; nd += rec_d[i]; end
      chk("xor busy cycles", cnt, 12);
      chk("xor done pulses", nd, 1);
      chk("xor done position", rec_d[12], 1);
      chk("xor pass", int'(ifa.pass), 1);
      chk("xor err_mask", int'(ifa.err_mask), 0);
      chk("busy write w0", int'(ifa.w0), 2);

      // Fault: y stuck at 1
      stub_one = 1;
      @(negedge clk);
      ifa.start = 1;
      @(negedge clk);
      ifa.start = 0;
      wait_idle("fault");
      chk("fault err_mask", int'(ifa.err_mask), 4'b1001);
      chk("fault pass", int'(ifa.pass), 0);
      chk("truth1111 err_mask", int'(ifb.err_mask), 0);
      chk("truth1111 pass", int'(ifb.pass), 1);
      stub_one = 0;
      @(negedge clk);

      // Same-edge start and write of w7
      ifa.start = 1; ifa.w_valid = 1; ifa.w_idx = 4'd7; ifa.w_data = 4'sd3;
      @(negedge clk);
      ifa.start = 0; ifa.w_valid = 0;
      chk("same-edge x_out", int'(ifa.x_out), 3);
      chk("same-edge w7", int'(ifa.w7), 3);
      wait_idle("same-edge");

      // start held high for 30 cycles
      ifa.start = 1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         rec_b[i] = int'(ifa.busy);
      end
      ifa.start = 0;
      r0 = -1; r1 = -1;
      for (int i = 0; i < 30; i++)
         if (rec_b[i] == 1 && (i == 0 || rec_b[i-1] == 0)) begin
            if (r0 < 0) r0 = i; else if (r1 < 0) r1 = i;
         end
      chk("held first run", r0, 0);
      chk("held run spacing", r1 - r0, 13);
      wait_idle("held");

      // Mid-run reset while x=2
      ifa.start = 1;
      @(negedge clk);
      ifa.start = 0;
      for (int k = 0; k < 20; k++) begin
         if (ifa.x_out == 2'd2) break;
         @(negedge clk);
      end
      chk("reached x=2", int'(ifa.x_out), 2);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("abort x_out", int'(ifa.x_out), 0);
      chk("abort busy", int'(ifa.busy), 0);
      chk("abort done", int'(ifa.done), 0);
      chk("abort pass", int'(ifa.pass), 0);
      chk("abort err_mask", int'(ifa.err_mask), 0);
      chk("abort w_ready", int'(ifa.w_ready), 1);
      chk("abort w5", int'(ifa.w5), 0);
      @(negedge clk);
      rst_n = 1;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         nd += int'(ifa.done);
      end
      chk("no done after abort", nd, 0);
      chk("w_ready after abort", int'(ifa.w_ready), 1);

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
